// File: rtl/traffic_signal_fsm.sv
// Two-way intersection signal controller with pedestrian phase, timed by a 1 Hz sec_clk.
// sec_clk rise to state/outputs update: 3 clkin edges; all outputs registered, no backpressure.
module traffic_signal_fsm #(
    parameter int GREEN_S  = 10,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 1,
    parameter int WALK_S   = 5
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       sec_clk,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] sec_left,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        RED1 = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        RED2 = 3'd5,
        WALK = 3'd6
    } state_t;

    localparam logic [7:0] GREEN_T  = 8'(GREEN_S);
    localparam logic [7:0] YELLOW_T = 8'(YELLOW_S);
    localparam logic [7:0] ALLRED_T = 8'(ALLRED_S);
    localparam logic [7:0] WALK_T   = 8'(WALK_S);

    state_t     state;
    state_t     nstate;
    logic       s1, s2, s3;
    logic       sec_tick;
    logic [7:0] timer;
    logic       ped_pending;
    logic       next_dir;
    logic       expire;

    function automatic logic [7:0] duration(state_t s);
        case (s)
            NS_G, EW_G: duration = GREEN_T;
            NS_Y, EW_Y: duration = YELLOW_T;
            RED1, RED2: duration = ALLRED_T;
            default:    duration = WALK_T;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(state_t s);
        case (s)
            NS_G:    ns_lamp = 3'b001;
            NS_Y:    ns_lamp = 3'b010;
            default: ns_lamp = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(state_t s);
        case (s)
            EW_G:    ew_lamp = 3'b001;
            EW_Y:    ew_lamp = 3'b010;
            default: ew_lamp = 3'b100;
        endcase
    endfunction

    // Synchroniser resets high to match the divider's post-reset level, so no tick follows reset.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= sec_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sec_tick = s2 & ~s3;
    assign expire   = sec_tick && (timer == 8'd1);

    always_comb begin
        nstate = state;
        case (state)
            NS_G:    nstate = NS_Y;
            NS_Y:    nstate = RED1;
            RED1:    nstate = ped_pending ? WALK : EW_G;
            EW_G:    nstate = EW_Y;
            EW_Y:    nstate = RED2;
            RED2:    nstate = ped_pending ? WALK : NS_G;
            WALK:    nstate = next_dir ? EW_G : NS_G;
            default: nstate = NS_G;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= NS_G;
            timer       <= GREEN_T;
            ped_pending <= 1'b0;
            next_dir    <= 1'b0;
            ns_light    <= 3'b001;
            ew_light    <= 3'b100;
            walk        <= 1'b0;
        end else begin
            if (expire) begin
                state    <= nstate;
                timer    <= duration(nstate);
                ns_light <= ns_lamp(nstate);
                ew_light <= ew_lamp(nstate);
                walk     <= (nstate == WALK);
                if (nstate == WALK)
                    next_dir <= (state == RED1);
            end else if (sec_tick) begin
                timer <= timer - 8'd1;
            end
            // Entry to WALK wins over a same-cycle request.
            if (expire && nstate == WALK)
                ped_pending <= 1'b0;
            else if (ped_req && state != WALK)
                ped_pending <= 1'b1;
        end
    end

    assign sec_left = timer;
    assign phase    = state;

endmodule

// File: tb/tb_traffic_signal_fsm.sv
// Randomised bench for traffic_signal_fsm against a phase/seconds reference model.
module tb_traffic_signal_fsm;

    localparam int GR = 3;
    localparam int YE = 2;
    localparam int AR = 1;
    localparam int WK = 4;

    logic       clkin = 1'b0;
    logic       reset;
    logic       sec_clk;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [7:0] sec_left;
    logic [2:0] phase;

    traffic_signal_fsm #(
        .GREEN_S (GR),
        .YELLOW_S(YE),
        .ALLRED_S(AR),
        .WALK_S  (WK)
    ) dut (
        .clkin   (clkin),
        .reset   (reset),
        .sec_clk (sec_clk),
        .ped_req (ped_req),
        .ns_light(ns_light),
        .ew_light(ew_light),
        .walk    (walk),
        .sec_left(sec_left),
        .phase   (phase)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    // Reference model: phase number, seconds remaining, pending request, post-walk destination.
    int m_ph, m_rem, m_pend, m_dest;
    int edge_n   = 0;
    int tick_q[$];
    int sc_run   = 0;
    int sc_cnt   = 4;
    int sc_fast  = 0;
    int ped_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, got, exp);
        end
    endtask

    function automatic int dur(int p);
        if (p == 0 || p == 3) return GR;
        if (p == 1 || p == 4) return YE;
        if (p == 2 || p == 5) return AR;
        return WK;
    endfunction

    function automatic int lamp_ns(int p);
        return (p == 0) ? 1 : (p == 1) ? 2 : 4;
    endfunction

    function automatic int lamp_ew(int p);
        return (p == 3) ? 1 : (p == 4) ? 2 : 4;
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_rem  = GR;
        m_pend = 0;
        m_dest = 0;
        tick_q.delete();
    endtask

    task automatic model_edge();
        int tick = 0;
        int old  = m_ph;
        int nx;
        int to_walk = 0;
        while (tick_q.size() > 0 && tick_q[0] <= edge_n) begin
            if (tick_q[0] == edge_n) tick = 1;
            void'(tick_q.pop_front());
        end
        if (tick) begin
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                case (m_ph)
                    0: nx = 1;
                    1: nx = 2;
                    2: nx = m_pend ? 6 : 3;
                    3: nx = 4;
                    4: nx = 5;
                    5: nx = m_pend ? 6 : 0;
                    default: nx = m_dest;
                endcase
                if (nx == 6) begin
                    m_dest  = (m_ph == 2) ? 3 : 0;
                    to_walk = 1;
                end
                m_ph  = nx;
                m_rem = dur(nx);
            end
        end
        if (to_walk) m_pend = 0;
        else if (ped_req && old != 6) m_pend = 1;
    endtask

    task automatic compare();
        chk("phase", phase, m_ph);
        chk("sec_left", sec_left, m_rem);
        chk("ns_light", ns_light, lamp_ns(m_ph));
        chk("ew_light", ew_light, lamp_ew(m_ph));
        chk("walk", walk, (m_ph == 6) ? 1 : 0);
        chk("inv_both_go", (ns_light != 3'b100) && (ew_light != 3'b100), 0);
        chk("inv_sec_nonzero", sec_left == 8'd0, 0);
    endtask

    task automatic drive_next();
        if (sc_run != 0) begin
            sc_cnt--;
            if (sc_cnt <= 0) begin
                sec_clk = ~sec_clk;
                if (sec_clk) tick_q.push_back(edge_n + 3);
                sc_cnt = sc_fast ? 4 : $urandom_range(4, 12);
            end
        end
        case (ped_mode)
            1: ped_req = ($urandom_range(0, 59) == 0);
            2: if ($urandom_range(0, 199) == 0) ped_req = ~ped_req;
            default: ped_req = 1'b0;
        endcase
    endtask

    task automatic step();
        @(posedge clkin);
        edge_n++;
        if (reset) model_reset();
        else model_edge();
        #1;
        compare();
        drive_next();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int ph, input int budget, input string tag);
        int n = 0;
        while (m_ph != ph && n < budget) begin
            step();
            n++;
        end
        chk(tag, phase, ph);
    endtask

    initial begin
        reset   = 1'b1;
        sec_clk = 1'b1;
        ped_req = 1'b0;
        model_reset();
        #1;
        compare();
        run(100);

        // Released with sec_clk idle: nothing may move.
        @(posedge clkin);
        #1;
        reset = 1'b0;
        run(30);

        // Plain cycling, no pedestrians.
        sc_run = 1;
        run(600);

        // One-cycle request in EW_G should be served after RED2, then return to NS_G.
        run_until(3, 2000, "reach_ew_g");
        ped_req = 1'b1;
        step();
        run_until(6, 2000, "reach_walk");
        chk("walk_lamp_on", walk, 1);
        run_until(0, 2000, "walk_to_ns_g");

        // Long held/toggling requests, including through WALK.
        ped_mode = 2;
        run(3000);

        // Fastest sec_clk with sporadic pulses.
        ped_mode = 1;
        sc_fast  = 1;
        run(1500);
        sc_fast  = 0;
        ped_mode = 0;
        ped_req  = 1'b0;

        // Reset in EW_Y with a pending request: request must be lost.
        run_until(3, 2000, "reach_ew_g_2");
        ped_req = 1'b1;
        step();
        run_until(4, 2000, "reach_ew_y");
        step();
        reset  = 1'b1;
        sc_run = 0;
        model_reset();
        #1;
        compare();
        run(3);
        reset  = 1'b0;
        sc_cnt = 6;
        sc_run = 1;
        run_until(2, 2000, "reach_red1_after_reset");
        run_until(3, 2000, "red1_to_ew_g_no_walk");
        run(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
